// File: rtl/adc_frame_align_ctrl.sv
// ADC frame-clock bitslip alignment controller, divclk domain.
// Optional per-lane data check: define ADC_LANE_CHECK_EN.
module adc_frame_align_ctrl #(
    parameter logic [7:0] FRAME_PATTERN = 8'h0F,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         LOCK_COUNT    = 64,
    parameter int         UNLOCK_COUNT  = 4,
    parameter int         MAX_SLIPS     = 8,
    parameter int         AUTO_START    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        align_start,
    input  logic [7:0]  fclk_deser,
    input  logic [63:0] data_deser,
`ifdef ADC_LANE_CHECK_EN
    input  logic [7:0]  test_pattern,
    output logic [7:0]  lane_ok,
    output logic [15:0] lane_err_cnt,
`endif
    output logic        bitslip,
    output logic        locked,
    output logic        align_fail,
    output logic [3:0]  slip_count,
    output logic [2:0]  state_dbg
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic [UW-1:0] miss_q, miss_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    slip_q, slip_d;
    logic          hit;

    assign hit = (fclk_deser == FRAME_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            match_q    <= '0;
            miss_q     <= '0;
            settle_q   <= '0;
            slip_q     <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            settle_q   <= settle_d;
            slip_q     <= slip_d;
            bitslip    <= (state_d == SLIP);
            locked     <= (state_d == LOCKED);
            align_fail <= (state_d == FAIL);
        end
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        miss_d   = miss_q;
        settle_d = settle_q;
        slip_d   = slip_q;
        unique case (state_q)
            IDLE: begin
                if (AUTO_START != 0) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    if (match_q == MW'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else begin
                    match_d = '0;
                    if (slip_q < 4'(MAX_SLIPS)) begin
                        state_d = SLIP;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            SLIP: begin
                if (slip_q < 4'(MAX_SLIPS)) begin
                    slip_d = slip_q + 4'd1;
                end
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                // incoming words are ignored while the SERDES re-settles
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    match_d  = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            LOCKED: begin
                if (hit) begin
                    miss_d = '0;
                end else if (miss_q == UW'(UNLOCK_COUNT - 1)) begin
                    miss_d  = '0;
                    match_d = '0;
                    slip_d  = '0;
                    state_d = CHECK;
                end else begin
                    miss_d = miss_q + UW'(1);
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // restart wins over every other transition this cycle
        if (align_start) begin
            state_d  = CHECK;
            match_d  = '0;
            miss_d   = '0;
            settle_d = '0;
            slip_d   = '0;
        end
    end

    assign slip_count = slip_q;
    assign state_dbg  = state_q;

`ifdef ADC_LANE_CHECK_EN
    logic [7:0]  lane_hit;
    logic [15:0] err_q;
    logic        in_lock;

    always_comb begin
        lane_hit = '0;
        for (int n = 0; n < 8; n++) begin
            lane_hit[n] = (data_deser[8*n +: 8] == test_pattern);
        end
    end

    assign in_lock = (state_q == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_ok <= '0;
            err_q   <= '0;
        end else if (align_start) begin
            lane_ok <= '0;
            err_q   <= '0;
        end else begin
            lane_ok <= (state_d == LOCKED) ? lane_hit : 8'h00;
            if (in_lock && (lane_hit != 8'hFF) && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign lane_err_cnt = in_lock ? err_q : 16'h0000;
`else
    logic data_unused;
    assign data_unused = ^data_deser;
`endif

endmodule
